multibyte_add_sched: RTL and testbench

- Sequencer and arbiter that shares one external 8-bit byte adder (carry_in, in_a, in_b, out, carry_out) between two requesters.
- Each accepted request is an add of up to MAX_BYTES bytes. Bytes are fed LSB first, one per cycle, with the carry chained through a register. The assembled result is returned on a valid/ready response channel.
- Sits between client logic and the combinational adder instance; the adder itself is instantiated alongside, not inside.

---
 rtl/multibyte_add_sched.sv | 244 ++++++++++++++++++++++++
 tb/tb_multibyte_add_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multibyte_add_sched.sv
// multibyte_add_sched: shares one external combinational 8-bit adder between
// two requesters. Each accepted request is added byte-serially, LSB first,
// with the carry chained through a register; the assembled result is
// returned on a valid/ready response channel.
// Optional feature: define MULTIBYTE_SUB_EN to add req0_sub/req1_sub ports
// and perform A-B (invert B, force initial carry to 1).
module multibyte_add_sched #(
    parameter int MAX_BYTES = 4,
    parameter int LEN_W     = 3,
    localparam int W        = 8 * MAX_BYTES
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req0_carry_in,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic [LEN_W-1:0] req1_len,
    input  logic             req1_carry_in,
`ifdef MULTIBYTE_SUB_EN
    input  logic             req0_sub,
    input  logic             req1_sub,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [W-1:0]     rsp_sum,
    output logic             rsp_carry_out,
    output logic             busy,
    output logic [7:0]       adder_in_a,
    output logic [7:0]       adder_in_b,
    output logic             adder_carry_in,
    input  logic [7:0]       adder_out,
    input  logic             adder_carry_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    state_t           state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] k_q, k_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic             id_q, id_d;
    logic             prefer1_q, prefer1_d;
`ifdef MULTIBYTE_SUB_EN
    logic             sub_q, sub_d;
    logic             sel_sub;
`endif

    logic             gnt_id;
    logic             hs;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    logic [LEN_W-1:0] sel_len;
    logic [LEN_W-1:0] len_clamped;
    logic             sel_cin;
    logic             sel_cin_eff;
    logic [LEN_W-1:0] k_next;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       b_eff;
    logic             first_carry;

    // Arbitration: lone requester wins; on contention the one not granted last wins
    always_comb begin
        if (req0_valid && req1_valid) begin
            gnt_id = prefer1_q;
        end else begin
            gnt_id = req1_valid;
        end
        req0_ready = (state_q == IDLE) && req0_valid && !gnt_id;
        req1_ready = (state_q == IDLE) && req1_valid && gnt_id;
        hs         = req0_ready || req1_ready;
        sel_a      = gnt_id ? req1_a        : req0_a;
        sel_b      = gnt_id ? req1_b        : req0_b;
        sel_len    = gnt_id ? req1_len      : req0_len;
        sel_cin    = gnt_id ? req1_carry_in : req0_carry_in;
        len_clamped = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
`ifdef MULTIBYTE_SUB_EN
        sel_sub     = gnt_id ? req1_sub : req0_sub;
        sel_cin_eff = sel_sub ? 1'b1 : sel_cin;
`else
        sel_cin_eff = sel_cin;
`endif
    end

    // Current operand bytes selected by the byte index
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (k_q == LEN_W'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
        k_next = k_q + LEN_W'(1);
`ifdef MULTIBYTE_SUB_EN
        b_eff       = sub_q ? ~b_byte : b_byte;
        first_carry = sub_q ? 1'b1 : cin_q;
`else
        b_eff       = b_byte;
        first_carry = cin_q;
`endif
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (k_next == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: adder drive only in RUN, response only in DONE
    always_comb begin
        busy           = (state_q != IDLE);
        rsp_valid      = (state_q == DONE);
        rsp_id         = (state_q == DONE) ? id_q    : 1'b0;
        rsp_sum        = (state_q == DONE) ? sum_q   : '0;
        rsp_carry_out  = (state_q == DONE) ? carry_q : 1'b0;
        adder_in_a     = '0;
        adder_in_b     = '0;
        adder_carry_in = 1'b0;
        if (state_q == RUN) begin
            adder_in_a     = a_byte;
            adder_in_b     = b_eff;
            adder_carry_in = (k_q == '0) ? first_carry : carry_q;
        end
    end

    // Datapath next-state: capture on handshake, accumulate one byte per RUN cycle.
    // The carry register is preloaded with the effective initial carry so a
    // zero-length request reports it directly as its carry out.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        len_d     = len_q;
        k_d       = k_q;
        cin_d     = cin_q;
        carry_d   = carry_q;
        id_d      = id_q;
        prefer1_d = prefer1_q;
`ifdef MULTIBYTE_SUB_EN
        sub_d     = sub_q;
`endif
        if (state_q == IDLE && hs) begin
            a_d       = sel_a;
            b_d       = sel_b;
            len_d     = len_clamped;
            cin_d     = sel_cin;
            id_d      = gnt_id;
            k_d       = '0;
            sum_d     = '0;
            carry_d   = sel_cin_eff;
            prefer1_d = !gnt_id;
`ifdef MULTIBYTE_SUB_EN
            sub_d     = sel_sub;
`endif
        end else if (state_q == RUN) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                if (k_q == LEN_W'(i)) begin
                    sum_d[8*i +: 8] = adder_out;
                end
            end
            carry_d = adder_carry_out;
            k_d     = k_next;
        end
    end

    // Datapath registers; reset clears everything so no stale result escapes
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            len_q     <= '0;
            k_q       <= '0;
            cin_q     <= 1'b0;
            carry_q   <= 1'b0;
            id_q      <= 1'b0;
            prefer1_q <= 1'b0;
`ifdef MULTIBYTE_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            len_q     <= len_d;
            k_q       <= k_d;
            cin_q     <= cin_d;
            carry_q   <= carry_d;
            id_q      <= id_d;
            prefer1_q <= prefer1_d;
`ifdef MULTIBYTE_SUB_EN
            sub_q     <= sub_d;
`endif
        end
    end

endmodule

// File: tb/tb_multibyte_add_sched.sv
// Scoreboard bench for multibyte_add_sched with an ideal adder stub.
module tb_multibyte_add_sched;

    localparam int MAX_BYTES = 4;
    localparam int LEN_W     = 3;
    localparam int W         = 32;

    logic             clock = 1'b0;
    logic             clear_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [W-1:0]     req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [LEN_W-1:0] req0_len = '0, req1_len = '0;
    logic             req0_carry_in = 1'b0, req1_carry_in = 1'b0;
    logic             req0_sub = 1'b0, req1_sub = 1'b0;
    logic             rsp_valid, rsp_id, rsp_carry_out, busy;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_sum;
    logic [7:0]       adder_in_a, adder_in_b, adder_out;
    logic             adder_carry_in, adder_carry_out;

    always #5 clock = ~clock;

    // Ideal combinational adder
    assign {adder_carry_out, adder_out} = {1'b0, adder_in_a} + {1'b0, adder_in_b} + {8'd0, adder_carry_in};

    multibyte_add_sched #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
        .clock(clock), .clear_n(clear_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_len(req0_len), .req0_carry_in(req0_carry_in),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_len(req1_len), .req1_carry_in(req1_carry_in),
`ifdef MULTIBYTE_SUB_EN
        .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_carry_out(rsp_carry_out), .busy(busy),
        .adder_in_a(adder_in_a), .adder_in_b(adder_in_b), .adder_carry_in(adder_carry_in),
        .adder_out(adder_out), .adder_carry_out(adder_carry_out)
    );

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        int           lat;
        int           hs_cyc;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           hs_cnt = 0;
    bit           arb_mode = 1'b0;
    int           arb_exp[$];
    logic [W-1:0] pe_sum[2];
    logic         pe_cout[2];
    int           pe_lat[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Handshake watcher (pushes hand-computed expectations) and response monitor
    int           rise_cyc = 0;
    logic         prev_valid = 1'b0;
    logic         hold_prev = 1'b0;
    logic         held_id, held_cout;
    logic [W-1:0] held_sum;
    always @(negedge clock) begin
        if (clear_n) begin
            check("one_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
            for (int p = 0; p < 2; p++) begin
                if ((p == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
                    sb_q.push_back('{id: p[0], sum: pe_sum[p], cout: pe_cout[p], lat: pe_lat[p], hs_cyc: cyc});
                    hs_cnt++;
                    if (arb_mode) begin
                        if (arb_exp.size() == 0) begin
                            check("arb_extra_grant", 64'd1, 64'd0);
                        end else begin
                            check("arb_order", p, arb_exp.pop_front());
                        end
                    end
                end
            end
            if (!busy || rsp_valid) begin
                check("adder_idle", {47'd0, adder_in_a, adder_in_b, adder_carry_in}, 64'd0);
            end
            if (rsp_valid && !prev_valid) rise_cyc = cyc;
            if (rsp_valid) begin
                check("ready_low_done", {62'd0, req0_ready, req1_ready}, 64'd0);
                if (hold_prev) begin
                    check("hold_sum", rsp_sum, held_sum);
                    check("hold_id_cout", {62'd0, rsp_id, rsp_carry_out}, {62'd0, held_id, held_cout});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_id", rsp_id, e.id);
                    check("rsp_sum", rsp_sum, e.sum);
                    check("rsp_cout", rsp_carry_out, e.cout);
                    check("latency", rise_cyc - e.hs_cyc, e.lat);
                end
            end
            hold_prev = rsp_valid && !rsp_ready;
            held_sum  = rsp_sum;
            held_id   = rsp_id;
            held_cout = rsp_carry_out;
            prev_valid = rsp_valid;
        end else begin
            hold_prev  = 1'b0;
            prev_valid = 1'b0;
        end
    end

    task automatic drive(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [LEN_W-1:0] len, input logic cin, input logic sub,
                         input logic [W-1:0] esum, input logic ecout, input int elat);
        pe_sum[p] = esum;
        pe_cout[p] = ecout;
        pe_lat[p] = elat;
        if (p == 0) begin
            req0_a = a; req0_b = b; req0_len = len; req0_carry_in = cin; req0_sub = sub; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_len = len; req1_carry_in = cin; req1_sub = sub; req1_valid = 1'b1;
        end
    endtask

    task automatic issue(input int p, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [LEN_W-1:0] len, input logic cin, input logic sub,
                         input logic [W-1:0] esum, input logic ecout, input int elat);
        bit got;
        got = 1'b0;
        drive(p, a, b, len, cin, sub, esum, ecout, elat);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if ((p == 0) ? req0_ready : req1_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("req_timeout", 64'd1, 64'd0);
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (sb_q.size() == 0 && !busy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("rsp_timeout", 64'd1, 64'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        // Reset state, with both requesters already valid for the arbitration test
        arb_exp = '{0, 1, 0, 1};
        drive(0, 32'h01, 32'h02, 3'd1, 1'b0, 1'b0, 32'h03, 1'b0, 2);
        drive(1, 32'h10, 32'h20, 3'd1, 1'b0, 1'b0, 32'h30, 1'b0, 2);
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy_valid", {62'd0, busy, rsp_valid}, 64'd0);
        check("rst_sum", rsp_sum, 64'd0);
        check("rst_id_cout", {62'd0, rsp_id, rsp_carry_out}, 64'd0);
        check("rst_adder", {47'd0, adder_in_a, adder_in_b, adder_carry_in}, 64'd0);
        arb_mode = 1'b1;
        clear_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            if (hs_cnt >= 4) begin
                got = 1'b1;
                break;
            end
        end
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) check("arb_timeout", 64'd1, 64'd0);
        wait_done();
        arb_mode = 1'b0;
        check("arb_remaining", arb_exp.size(), 64'd0);

        // Single requester granted repeatedly
        issue(1, 32'h00FFFFFF, 32'h00000000, 3'd3, 1'b1, 1'b0, 32'h00000000, 1'b1, 4);
        wait_done();
        issue(1, 32'h80FF00FF, 32'h80010001, 3'd4, 1'b0, 1'b0, 32'h01000100, 1'b1, 5);
        wait_done();
        issue(0, 32'h11223344, 32'h01010101, 3'd1, 1'b0, 1'b0, 32'h00000045, 1'b0, 2);
        wait_done();
        issue(0, 32'h01010101, 32'h01010101, 3'd7, 1'b0, 1'b0, 32'h02020202, 1'b0, 5);
        wait_done();

        // Carry chain, full-width wrap, zero length
        issue(0, 32'h000000FF, 32'h00000001, 3'd2, 1'b0, 1'b0, 32'h00000100, 1'b0, 3);
        wait_done();
        issue(1, 32'hFFFFFFFF, 32'h00000001, 3'd4, 1'b0, 1'b0, 32'h00000000, 1'b1, 5);
        wait_done();
        issue(0, 32'h12345678, 32'h9ABCDEF0, 3'd0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1);
        wait_done();

        // Backpressure: hold the response for 5 cycles
        rsp_ready = 1'b0;
        issue(1, 32'h00001234, 32'h00004321, 3'd2, 1'b0, 1'b0, 32'h00005555, 1'b0, 3);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("bp_timeout", 64'd1, 64'd0);
        repeat (5) @(negedge clock);
        rsp_ready = 1'b1;
        wait_done();

        // Reset in the middle of RUN: operation vanishes, next one is clean
        issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0, 1'b0, 32'hFFFFFFFE, 1'b1, 5);
        @(posedge clock);
        #1;
        clear_n = 1'b0;
        sb_q.delete();
        @(posedge clock);
        #1;
        check("midrst_busy_valid", {62'd0, busy, rsp_valid}, 64'd0);
        check("midrst_sum", rsp_sum, 64'd0);
        check("midrst_adder", {47'd0, adder_in_a, adder_in_b, adder_carry_in}, 64'd0);
        clear_n = 1'b1;
        repeat (6) @(negedge clock);
        check("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        issue(1, 32'h00000102, 32'h00000304, 3'd2, 1'b1, 1'b0, 32'h00000407, 1'b0, 3);
        wait_done();

`ifdef MULTIBYTE_SUB_EN
        issue(0, 32'h00000010, 32'h00000001, 3'd1, 1'b0, 1'b1, 32'h0000000F, 1'b1, 2);
        wait_done();
        issue(0, 32'h00000000, 32'h00000001, 3'd1, 1'b0, 1'b1, 32'h000000FF, 1'b0, 2);
        wait_done();
`endif

        check("sb_empty", sb_q.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
